// File: rtl/decoder_grant_sequencer.sv
// decoder_grant_sequencer
// Round-robin arbiter that drives the address/enable pins of a downstream
// 2-to-4 enable decoder. The address is set up one cycle before enable rises
// and held one cycle after enable falls, so the decoder sees a glitch-free,
// break-before-make select.
//
// Optional feature: define GRANT_TIMEOUT_EN to force-end a grant after
// HOLD_MAX enable cycles and pulse the timeout output. Without the macro a
// grant lasts until done or until the request drops, and timeout is tied 0.
module decoder_grant_sequencer #(
    parameter int HOLD_MAX  = 15,
    parameter int CNT_WIDTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    output logic       addr0,
    output logic       addr1,
    output logic       enable,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Last counter value of a grant; the counter also parks here so it never
    // wraps during very long grants.
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_MAX - 1);

    state_t               state_q, state_d;
    logic [1:0]           addr_q, addr_d;
    logic [1:0]           last_q, last_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 enable_q, enable_d;
    logic                 busy_q, busy_d;
    logic                 req_cur;
`ifdef GRANT_TIMEOUT_EN
    logic                 timeout_q, timeout_d;
`endif

    // First set request scanning last+1, last+2, last+3, last (mod 4).
    function automatic logic [1:0] pick_winner(input logic [3:0] r,
                                               input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        pick_winner = last;
        found       = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && r[idx]) begin
                pick_winner = idx;
                found       = 1'b1;
            end
        end
    endfunction

    // The held address always names the current winner once it is loaded.
    assign req_cur = req[addr_q];

    // Next-state, address/pointer and registered-output decode.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        cnt_d   = '0;
`ifdef GRANT_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    addr_d  = pick_winner(req, last_q);
                    last_d  = addr_d;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // A request that vanished before enable is simply abandoned.
                state_d = req_cur ? GRANT : IDLE;
            end
            GRANT: begin
                cnt_d = (cnt_q == HOLD_LAST) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                if (done || !req_cur) begin
                    state_d = RELEASE;
                end
`ifdef GRANT_TIMEOUT_EN
                else if (cnt_q == HOLD_LAST) begin
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                end
`endif
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        enable_d = (state_d == GRANT);
        busy_d   = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= 2'd0;
            last_q   <= 2'd3;
            cnt_q    <= '0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
        end
    end

`ifdef GRANT_TIMEOUT_EN
    // One-cycle timeout pulse, aligned with the forced RELEASE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign addr0  = addr_q[0];
    assign addr1  = addr_q[1];
    assign enable = enable_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_decoder_grant_sequencer.sv
// Scoreboard bench for decoder_grant_sequencer: each directed cycle pushes its
// hand-computed expected outputs; a monitor pops and compares after every edge.
module tb_decoder_grant_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic       addr0, addr1, enable, busy, timeout;

    typedef struct {
        logic [4:0] val;   // {addr[1:0], enable, busy, timeout}
        logic       rst;
        string      tag;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       prev_en = 1'b0;
    logic [1:0] prev_addr = 2'd0;

    decoder_grant_sequencer #(.HOLD_MAX(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .addr0(addr0), .addr1(addr1), .enable(enable), .busy(busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and record what the outputs must be after the edge.
    task automatic cyc(input string tag, input logic r, input logic [3:0] rq,
                       input logic d, input logic [1:0] ea, input logic ee,
                       input logic eb, input logic et);
        exp_t e;
        @(negedge clk);
        reset = r;
        req   = rq;
        done  = d;
        e.val = {ea, ee, eb, et};
        e.rst = r;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: compare outputs and the address-stability invariant.
    always @(posedge clk) begin
        exp_t       e;
        logic [4:0] act;
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {addr1, addr0, enable, busy, timeout};
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got addr=%0d en=%b busy=%b to=%b, want addr=%0d en=%b busy=%b to=%b",
                         e.tag, act[4:3], act[2], act[1], act[0],
                         e.val[4:3], e.val[2], e.val[1], e.val[0]);
            end
            if (prev_en && !e.rst) begin
                checks++;
                if ({addr1, addr0} !== prev_addr) begin
                    errors++;
                    $display("FAIL addr_stable(%s): addr=%0d changed from %0d while enable high",
                             e.tag, {addr1, addr0}, prev_addr);
                end
            end
            prev_en   = enable;
            prev_addr = {addr1, addr0};
        end
    end

    initial begin
        logic [1:0] seq [3];
        seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3;

        cyc("reset0", 1, 4'b0000, 0, 0, 0, 0, 0);
        cyc("reset1", 1, 4'b0000, 0, 0, 0, 0, 0);

        // Single requester, three enable cycles, done with request drop.
        cyc("t1_setup", 0, 4'b0001, 0, 0, 0, 1, 0);
        cyc("t1_en1",   0, 4'b0001, 0, 0, 1, 1, 0);
        cyc("t1_en2",   0, 4'b0001, 0, 0, 1, 1, 0);
        cyc("t1_en3",   0, 4'b0001, 0, 0, 1, 1, 0);
        cyc("t1_rel",   0, 4'b0000, 1, 0, 0, 1, 0);
        cyc("t1_idle",  0, 4'b0000, 0, 0, 0, 0, 0);
        cyc("t1_idle2", 0, 4'b0000, 0, 0, 0, 0, 0);

        // All requesting: rotation 1,2,3 then 0, 3-cycle enable-low gap.
        for (int g = 0; g < 3; g++) begin
            cyc("t2_setup", 0, 4'b1111, 0, seq[g], 0, 1, 0);
            cyc("t2_grant", 0, 4'b1111, 0, seq[g], 1, 1, 0);
            cyc("t2_rel",   0, 4'b1111, 1, seq[g], 0, 1, 0);
            cyc("t2_idle",  0, 4'b1111, 0, seq[g], 0, 0, 0);
        end
        cyc("t2_setup0", 0, 4'b1111, 0, 0, 0, 1, 0);
        cyc("t2_grant0", 0, 4'b1111, 0, 0, 1, 1, 0);
        cyc("t2_rel0",   0, 4'b0000, 1, 0, 0, 1, 0);
        cyc("t2_idle0",  0, 4'b0000, 0, 0, 0, 0, 0);

        // Grant 1, then 0011 wraps to 0, then 0010 alone re-grants 1.
        cyc("t3_setup1", 0, 4'b0010, 0, 1, 0, 1, 0);
        cyc("t3_grant1", 0, 4'b0010, 0, 1, 1, 1, 0);
        cyc("t3_rel1",   0, 4'b0000, 1, 1, 0, 1, 0);
        cyc("t3_idle1",  0, 4'b0000, 0, 1, 0, 0, 0);
        cyc("t3_wrap0",  0, 4'b0011, 0, 0, 0, 1, 0);
        cyc("t3_grant0", 0, 4'b0011, 0, 0, 1, 1, 0);
        cyc("t3_rel0",   0, 4'b0010, 1, 0, 0, 1, 0);
        cyc("t3_idle0",  0, 4'b0010, 0, 0, 0, 0, 0);
        cyc("t3_setupr", 0, 4'b0010, 0, 1, 0, 1, 0);
        cyc("t3_grantr", 0, 4'b0010, 0, 1, 1, 1, 0);
        cyc("t3_relr",   0, 4'b0000, 1, 1, 0, 1, 0);
        cyc("t3_idler",  0, 4'b0000, 0, 1, 0, 0, 0);

        // Request dropped in SETUP (no enable, no RELEASE), then in GRANT.
        cyc("t4_setup",  0, 4'b0100, 0, 2, 0, 1, 0);
        cyc("t4_abort",  0, 4'b0000, 0, 2, 0, 0, 0);
        cyc("t4_idle",   0, 4'b0000, 0, 2, 0, 0, 0);
        cyc("t4_setup2", 0, 4'b0100, 0, 2, 0, 1, 0);
        cyc("t4_grant2", 0, 4'b0100, 0, 2, 1, 1, 0);
        cyc("t4_drop",   0, 4'b0000, 0, 2, 0, 1, 0);
        cyc("t4_idle2",  0, 4'b0000, 0, 2, 0, 0, 0);

        // Reset mid-grant, then index 3 wins from the reset pointer.
        cyc("t5_setup",  0, 4'b1000, 0, 3, 0, 1, 0);
        cyc("t5_grant",  0, 4'b1000, 0, 3, 1, 1, 0);
        cyc("t5_grant2", 0, 4'b1000, 0, 3, 1, 1, 0);
        cyc("t5_reset",  1, 4'b1000, 0, 0, 0, 0, 0);
        cyc("t5_setup3", 0, 4'b1000, 0, 3, 0, 1, 0);
        cyc("t5_grant3", 0, 4'b1000, 0, 3, 1, 1, 0);
        cyc("t5_rel3",   0, 4'b0000, 1, 3, 0, 1, 0);
        cyc("t5_idle3",  0, 4'b0000, 0, 3, 0, 0, 0);

        // Long grant on index 1 with done held low (HOLD_MAX = 4).
        cyc("t6_setup", 0, 4'b0010, 0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            cyc("t6_hold", 0, 4'b0010, 0, 1, 1, 1, 0);
`ifdef GRANT_TIMEOUT_EN
        cyc("t6_timeout", 0, 4'b0010, 0, 1, 0, 1, 1);
        cyc("t6_idle",    0, 4'b0010, 0, 1, 0, 0, 0);
        cyc("t6_resetup", 0, 4'b0010, 0, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            cyc("t6_rehold", 0, 4'b0010, 0, 1, 1, 1, 0);
        cyc("t6_hold4",   0, 4'b0010, 0, 1, 1, 1, 0);
        cyc("t6_donelim", 0, 4'b0010, 1, 1, 0, 1, 0);
        cyc("t6_end",     0, 4'b0000, 0, 1, 0, 0, 0);
`else
        for (int i = 0; i < 20; i++)
            cyc("t6_nolimit", 0, 4'b0010, 0, 1, 1, 1, 0);
        cyc("t6_rel",  0, 4'b0000, 1, 1, 0, 1, 0);
        cyc("t6_end",  0, 4'b0000, 0, 1, 0, 0, 0);
`endif

        cyc("final_idle", 0, 4'b0000, 0, 1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
